// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-sequencing controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_PAUSE = 8'h50;
    localparam logic [7:0] CMD_ABORT = 8'h52;

    typedef struct packed {
        logic start;
        logic pause;
        logic abort;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic dv, input logic [7:0] rx_byte);
        cmd_t c;
        c.start = dv && (rx_byte == CMD_START);
        c.pause = dv && (rx_byte == CMD_PAUSE);
        c.abort = dv && (rx_byte == CMD_ABORT);
        return c;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Command/event inputs and game-status outputs of the Pong sequencing controller.
interface pong_game_ctrl_if;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_Frame_Tick;
    logic       i_Miss_P1;
    logic       i_Miss_P2;
    logic       o_Game_Active;
    logic       o_Ball_Reset;
    logic [3:0] o_Score_P1;
    logic [3:0] o_Score_P2;
    logic [1:0] o_Winner;
    logic [2:0] o_State;

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Frame_Tick, i_Miss_P1, i_Miss_P2,
        output o_Game_Active, o_Ball_Reset, o_Score_P1, o_Score_P2, o_Winner, o_State
    );

    modport master (
        output i_RX_DV, i_RX_Byte, i_Frame_Tick, i_Miss_P1, i_Miss_P2,
        input  o_Game_Active, o_Ball_Reset, o_Score_P1, o_Score_P2, o_Winner, o_State
    );
endinterface

// File: rtl/pong_game_ctrl_serve_timer.sv
// Frame-tick counter for the serve delay; done_o flags the tick that reaches terminal count.
module serve_timer #(
    parameter int unsigned c_SERVE_FRAMES = 60
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic done_o
);
    localparam int unsigned W = $clog2(c_SERVE_FRAMES + 1);
    localparam logic [W-1:0] TERM = W'(c_SERVE_FRAMES);
    localparam logic [W-1:0] LAST = W'(c_SERVE_FRAMES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Done is combinational so the FSM can leave SERVE on the same edge the count lands.
    assign done_o = tick_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: command decode, serve/play/pause/game-over FSM and score keeping.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned c_SCORE_LIMIT  = 9,
    parameter int unsigned c_SERVE_FRAMES = 60
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    pong_game_ctrl_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(c_SCORE_LIMIT);

    state_t     state_q, state_d;
    logic       active_q, active_d;
    logic       ball_rst_q, ball_rst_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    winner_t    win_q, win_d;

    cmd_t cmd;
    logic serve_clear;
    logic serve_tick;
    logic serve_done;

    assign cmd        = decode_cmd(bus.i_RX_DV, bus.i_RX_Byte);
    assign serve_tick = bus.i_Frame_Tick && (state_q == ST_SERVE) && !cmd.abort;

    serve_timer #(
        .c_SERVE_FRAMES(c_SERVE_FRAMES)
    ) u_serve_timer (
        .clk_i   (i_Clk),
        .rst_i   (i_Rst),
        .clear_i (serve_clear),
        .tick_i  (serve_tick),
        .done_o  (serve_done)
    );

    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        win_d       = win_q;
        ball_rst_d  = 1'b0;
        serve_clear = 1'b0;

        if (cmd.abort) begin
            state_d = ST_IDLE;
            p1_d    = '0;
            p2_d    = '0;
            win_d   = WIN_NONE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (cmd.start) begin
                        state_d     = ST_SERVE;
                        p1_d        = '0;
                        p2_d        = '0;
                        win_d       = WIN_NONE;
                        ball_rst_d  = 1'b1;
                        serve_clear = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (serve_done) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (bus.i_Miss_P1 && bus.i_Miss_P2) begin
                        state_d    = ST_POINT;
                        ball_rst_d = 1'b1;
                    end else if (bus.i_Miss_P1) begin
                        if (p2_q != LIMIT) p2_d = p2_q + 4'd1;
                        if (p2_d == LIMIT) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P2;
                        end else begin
                            state_d    = ST_POINT;
                            ball_rst_d = 1'b1;
                        end
                    end else if (bus.i_Miss_P2) begin
                        if (p1_q != LIMIT) p1_d = p1_q + 4'd1;
                        if (p1_d == LIMIT) begin
                            state_d = ST_GAME_OVER;
                            win_d   = WIN_P1;
                        end else begin
                            state_d    = ST_POINT;
                            ball_rst_d = 1'b1;
                        end
                    end else if (cmd.pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (cmd.pause) state_d = ST_PLAY;
                end
                ST_POINT: begin
                    state_d     = ST_SERVE;
                    serve_clear = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        active_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            active_q   <= 1'b0;
            ball_rst_q <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            win_q      <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            ball_rst_q <= ball_rst_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            win_q      <= win_d;
        end
    end

    assign bus.o_Game_Active = active_q;
    assign bus.o_Ball_Reset  = ball_rst_q;
    assign bus.o_Score_P1    = p1_q;
    assign bus.o_Score_P2    = p2_q;
    assign bus.o_Winner      = win_q;
    assign bus.o_State       = state_q;

endmodule
